// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared constants and mux-select type for the fetch PC generator
package pc_gen_pkg;

    localparam int DEFAULT_ADDR_W = 32;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic Branch      = 1'b1;
    localparam logic NotBranch   = 1'b0;
    localparam logic Stop        = 1'b1;
    localparam logic NoStop      = 1'b0;
    localparam logic RstEnable   = 1'b1;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_FLUSH,
        PC_BRANCH,
        PC_PENDING
    } pc_sel_e;

endpackage

// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch-stage control inputs and instruction-memory outputs of pc_gen
interface pc_gen_if
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [ADDR_W-1:0]  new_pc;
    logic               branch_flag_i;
    logic [ADDR_W-1:0]  branch_target_address_i;
    logic [ADDR_W-1:0]  pc;
    logic               ce;
    logic               redirect_pending_o;
    logic               misaligned_o;

    modport master (
        input  stall, flush, new_pc, branch_flag_i, branch_target_address_i,
        output pc, ce, redirect_pending_o, misaligned_o
    );

    modport slave (
        output stall, flush, new_pc, branch_flag_i, branch_target_address_i,
        input  pc, ce, redirect_pending_o, misaligned_o
    );
endinterface

// File: rtl/pc_redirect_buf.sv
// rtl/pc_redirect_buf.sv - holds a branch target that arrived while fetch was stalled
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] target,
    output logic              pending,
    output logic [ADDR_W-1:0] buf_target
);

    // load wins over clear so a newer stalled branch always replaces the older one
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pending    <= 1'b0;
            buf_target <= '0;
        end else if (load) begin
            pending    <= 1'b1;
            buf_target <= target;
        end else if (clear) begin
            pending    <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program counter with stall, branch buffering and flush redirect
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W       = DEFAULT_ADDR_W,
    parameter int                INST_BYTES   = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                STALL_W      = 6
)(
    input  logic      clk,
    input  logic      rst,
    pc_gen_if.master  bus
);

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(PC_STEP - 1'b1);

    logic              stall0;
    logic              unused_stall;
    logic              pending;
    logic [ADDR_W-1:0] buf_target;
    logic [ADDR_W-1:0] raw_target;
    logic              buf_load;
    logic              buf_clear;
    pc_sel_e           sel;

    assign stall0       = bus.stall[0];
    assign unused_stall = ^bus.stall;

    always_comb begin
        sel        = PC_INC;
        raw_target = bus.new_pc;
        if (bus.flush) begin
            sel = PC_FLUSH;
        end else if (bus.branch_flag_i == Branch && stall0 == NoStop) begin
            sel        = PC_BRANCH;
            raw_target = bus.branch_target_address_i;
        end else if (bus.branch_flag_i == Branch) begin
            sel = PC_HOLD;
        end else if (pending && stall0 == NoStop) begin
            sel        = PC_PENDING;
            raw_target = buf_target;
        end else if (stall0 == Stop) begin
            sel = PC_HOLD;
        end
    end

    // any unstalled or flushing edge consumes (or supersedes) the buffered target
    assign buf_load  = (bus.ce == ChipEnable) && !bus.flush &&
                       (bus.branch_flag_i == Branch) && (stall0 == Stop);
    assign buf_clear = (bus.ce == ChipEnable) && (bus.flush || stall0 == NoStop);

    pc_redirect_buf #(.ADDR_W(ADDR_W)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .clear      (buf_clear),
        .target     (bus.branch_target_address_i),
        .pending    (pending),
        .buf_target (buf_target)
    );

    assign bus.redirect_pending_o = pending;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            bus.ce           <= ChipDisable;
            bus.pc           <= RESET_VECTOR;
            bus.misaligned_o <= 1'b0;
        end else if (bus.ce == ChipDisable) begin
            bus.ce           <= ChipEnable;
            bus.pc           <= RESET_VECTOR;
            bus.misaligned_o <= 1'b0;
        end else begin
            bus.misaligned_o <= 1'b0;
            case (sel)
                PC_FLUSH, PC_BRANCH, PC_PENDING: begin
                    bus.pc           <= raw_target & ALIGN_MASK;
                    bus.misaligned_o <= |(raw_target & ~ALIGN_MASK);
                end
                PC_INC:  bus.pc <= bus.pc + PC_STEP;
                default: bus.pc <= bus.pc;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed vector bench for pc_gen
module tb_pc_gen;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pc_gen_if #(.ADDR_W(32), .STALL_W(6)) bus ();

    pc_gen #(
        .ADDR_W(32), .INST_BYTES(4), .RESET_VECTOR(32'h0), .STALL_W(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic        e_ce;
        logic        e_pend;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input logic r, input logic s, input logic f, input logic [31:0] np,
                       input logic b, input logic [31:0] t, input logic [31:0] epc,
                       input logic ece, input logic epend, input logic emis);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.new_pc = np; v.br = b; v.tgt = t;
        v.e_pc = epc; v.e_ce = ece; v.e_pend = epend; v.e_mis = emis;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic [31:0] np,
                         input logic b, input logic [31:0] t);
        rst                         = r;
        bus.stall                   = {5'b10110, s};
        bus.flush                   = f;
        bus.new_pc                  = np;
        bus.branch_flag_i           = b;
        bus.branch_target_address_i = t;
    endtask

    task automatic check_all(input string tag, input logic [31:0] epc, input logic ece,
                             input logic epend, input logic emis);
        chk({tag, ".pc"},   bus.pc, epc);
        chk({tag, ".ce"},   {31'b0, bus.ce}, {31'b0, ece});
        chk({tag, ".pend"}, {31'b0, bus.redirect_pending_o}, {31'b0, epend});
        chk({tag, ".mis"},  {31'b0, bus.misaligned_o}, {31'b0, emis});
    endtask

    initial begin
        //   rst st fl new_pc        br tgt           exp_pc        ce pd ms
        add(1, 0, 0, 32'h0,        0, 32'h0,       32'h0,        0, 0, 0);
        add(1, 1, 1, 32'h80,       1, 32'h100,     32'h0,        0, 0, 0);
        add(1, 0, 0, 32'h0,        0, 32'h0,       32'h0,        0, 0, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,       32'h0,        1, 0, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,       32'h4,        1, 0, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,       32'h8,        1, 0, 0);
        // branch under a three-cycle stall
        add(0, 1, 0, 32'h0,        1, 32'h100,     32'h8,        1, 1, 0);
        add(0, 1, 0, 32'h0,        0, 32'h0,       32'h8,        1, 1, 0);
        add(0, 1, 0, 32'h0,        0, 32'h0,       32'h8,        1, 1, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,       32'h100,      1, 0, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,       32'h104,      1, 0, 0);
        // newer stalled branch overwrites
        add(0, 1, 0, 32'h0,        1, 32'h100,     32'h104,      1, 1, 0);
        add(0, 1, 0, 32'h0,        1, 32'h200,     32'h104,      1, 1, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,       32'h200,      1, 0, 0);
        // branch in the release cycle beats the pending one
        add(0, 1, 0, 32'h0,        1, 32'h100,     32'h200,      1, 1, 0);
        add(0, 0, 0, 32'h0,        1, 32'h300,     32'h300,      1, 0, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,       32'h304,      1, 0, 0);
        // flush beats stall, branch and pending
        add(0, 1, 0, 32'h0,        1, 32'h40,      32'h304,      1, 1, 0);
        add(0, 1, 1, 32'h20,       1, 32'h100,     32'h20,       1, 0, 0);
        add(0, 1, 0, 32'h0,        0, 32'h0,       32'h20,       1, 0, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,       32'h24,       1, 0, 0);
        // misaligned direct branch
        add(0, 0, 0, 32'h0,        1, 32'h103,     32'h100,      1, 0, 1);
        add(0, 0, 0, 32'h0,        0, 32'h0,       32'h104,      1, 0, 0);
        // misaligned buffered branch flagged on application
        add(0, 1, 0, 32'h0,        1, 32'h201,     32'h104,      1, 1, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,       32'h200,      1, 0, 1);
        add(0, 0, 0, 32'h0,        0, 32'h0,       32'h204,      1, 0, 0);
        // misaligned flush, then wrap
        add(0, 0, 1, 32'hFFFF_FFFE, 0, 32'h0,      32'hFFFF_FFFC, 1, 0, 1);
        add(0, 0, 0, 32'h0,        0, 32'h0,       32'h0,        1, 0, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,       32'h4,        1, 0, 0);
        // reset discards a pending target
        add(0, 1, 0, 32'h0,        1, 32'h100,     32'h4,        1, 1, 0);
        add(1, 1, 0, 32'h0,        0, 32'h0,       32'h0,        0, 0, 0);
        add(1, 1, 0, 32'h0,        1, 32'h500,     32'h0,        0, 0, 0);
        add(0, 1, 1, 32'h80,       1, 32'h700,     32'h0,        1, 0, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,       32'h4,        1, 0, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,       32'h8,        1, 0, 0);

        drive(1, 0, 0, 32'h0, 0, 32'h0);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].new_pc,
                  vecs[i].br, vecs[i].tgt);
            @(posedge clk);
            #1;
            check_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_ce,
                      vecs[i].e_pend, vecs[i].e_mis);
        end

        // long stall: buffered target must survive five held cycles
        drive(0, 1, 0, 32'h0, 1, 32'h40);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("hold%0d", k), 32'h8, 1'b1, 1'b1, 1'b0);
            drive(0, 1, 0, 32'h0, 0, 32'h0);
        end
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        @(posedge clk);
        #1;
        check_all("release", 32'h40, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("after_release", 32'h44, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the instruction-fetch stage, the successor to the fixed 32-bit PC register. It drives the instruction-memory address and chip enable. It honours the control module's stall vector, takes branch redirects from ID, and takes exception/flush redirects from the control module. A branch that arrives while fetch is stalled is buffered and applied when the stall releases, so the redirect is never lost.

## Interface
- ADDR_W, 32, PC / target width in bits
- INST_BYTES, 4, PC increment per fetch; power of two ≥ 1
- RESET_VECTOR, 0, first fetch address after reset; must be INST_BYTES-aligned
- STALL_W, 6, width of the control-module stall vector; bit 0 is the fetch stage
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  STALL_W  pipeline stall vector; only stall[0] affects this block
- flush  in  1  exception/flush redirect, highest priority
- new_pc  in  ADDR_W  flush target
- branch_flag_i  in  1  branch taken in ID this cycle
- branch_target_address_i  in  ADDR_W  branch target
- pc  out  ADDR_W  instruction fetch address
- ce  out  1  instruction memory chip enable
- redirect_pending_o  out  1  a branch target is buffered, awaiting stall release
- misaligned_o  out  1  registered one-cycle pulse: the last applied target had nonzero low bits

## Operation
- Reset (rst=1 at an edge) sets ce=0, pc=RESET_VECTOR, redirect_pending_o=0, misaligned_o=0, and clears the pending buffer.
- ce rises at the first edge with rst=0.
- While ce=0, pc holds RESET_VECTOR, and flush, branch and stall are all ignored.
- Per-edge priority when ce=1:
  1. flush: pc←new_pc. Clears pending. Ignores stall and branch.
  2. branch_flag_i with stall[0]=0: pc←branch_target_address_i. Clears pending. A branch in the release cycle beats any pending target.
  3. branch_flag_i with stall[0]=1: pc holds. Buffer←target and pending←1. A newer branch overwrites an older buffered one.
  4. pending with stall[0]=0: pc←buffer, pending←0.
  5. stall[0]=1: pc holds.
  6. Otherwise pc←pc+INST_BYTES, truncated to ADDR_W (wraps from 2^ADDR_W−INST_BYTES to 0).
- Alignment:
  - Every applied target (flush, branch or buffered) has its low log2(INST_BYTES) bits forced to 0.
  - misaligned_o is set to 1 for the next cycle if the discarded bits were nonzero. Otherwise it is 0.
  - The check is made at application time, not at buffering time.
- redirect_pending_o is the registered pending bit.
- rst asserted mid-stall or mid-pending discards the buffered target.

## Timing
- pc, ce and the flags are registered; no combinational input→output path.
- Redirect latency: target appears on pc one edge after flush or unstalled branch_flag_i is sampled.
- Buffered redirect: target appears on pc at the first edge where stall[0]=0, with no extra bubble.
- Reset release: the edge that samples rst=0 sets ce=1. The first fetch address, RESET_VECTOR, is valid on that same cycle. The next edge advances to RESET_VECTOR+INST_BYTES.
- Flush and branch in the same cycle: flush wins; the branch is dropped, not buffered.

## Structure
- Shared defines/package holds ChipEnable/ChipDisable, Branch/NotBranch, Stop/NoStop, RstEnable, and the default ADDR_W.
- The alignment mask is a localparam derived from INST_BYTES.
- One natural sub-module is pc_redirect_buf: the pending target register, valid bit, overwrite-on-new-branch and clear-on-apply/flush/reset. pc_gen holds the priority mux, the incrementer and ce.

## Test plan
- Reset then run: rst 3 cycles, release, no stalls.
  - ce=0 and pc=0 during reset.
  - ce=1 with pc=0x0, then 0x4, 0x8 on successive cycles.
- Branch under stall:
  - Stimulus: stall[0]=1 for 3 cycles, branch to 0x100 in the first of them.
  - While stalled: pc holds and redirect_pending_o=1.
  - On release: pc=0x100 on the first unstalled edge, then pending=0.
- Double branch and release-cycle branch:
  - Branches 0x100 then 0x200 while stalled: pc becomes 0x200 on release.
  - A separate run with pending 0x100 and branch 0x300 in the release cycle: pc becomes 0x300.
- Flush priority:
  - flush new_pc=0x20 together with branch 0x100 while stall[0]=1.
  - Next cycle: pc=0x20, pending cleared.
- Wrap and misalignment:
  - pc=0xFFFF_FFFC unstalled: next pc=0x0.
  - Branch to 0x103: pc=0x100 and misaligned_o pulses for one cycle.
- Reset mid-pending:
  - Buffer 0x100, then assert rst.
  - After release: pc restarts at RESET_VECTOR and 0x100 never appears.
